algo_mrnw_queue_sched: RTL and testbench

Pop scheduler in front of the multi-port linked-list queue top (`algo_mrnw_queue_top`).
- Tracks per-queue occupancy from the push stream and per-queue pop demand from consumers.
- Grants up to NUMPOPT pops per cycle across non-empty queues, round-robin, bounded by an outstanding-pop credit limit.
- Provides a pause/drain sequence so software can quiesce the queue before reconfiguration.

---
 rtl/algo_mrnw_queue_pkg.sv | 15 +
 rtl/algo_mrnw_rr_pick.sv | 41 ++++
 rtl/algo_mrnw_queue_sched.sv | 167 ++++++++++++++++
 tb/tb_algo_mrnw_queue_sched.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/algo_mrnw_queue_pkg.sv
`default_nettype none
// algo_mrnw_queue_pkg: shared scheduler state encoding and count widths.
// Rev 1.0
package algo_mrnw_queue_pkg;
   typedef enum logic [1:0] {
      ST_INIT  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_HALT  = 2'd3
   } state_t;

   localparam int BITADDR_DFLT = 13;
   localparam int OCC_W_DFLT   = BITADDR_DFLT + 1;
endpackage
`default_nettype wire

// File: rtl/algo_mrnw_rr_pick.sv
`default_nettype none
// algo_mrnw_rr_pick: rotating multi-pick, up to NUMPOPT distinct eligible queues from ptr upward.
// Rev 1.0
module algo_mrnw_rr_pick #(
   parameter int NUMQUEU = 8,
   parameter int BITQUEU = 3,
   parameter int NUMPOPT = 1
) (
   input  logic [NUMQUEU-1:0]         elig,
   input  logic [BITQUEU-1:0]         ptr,
   output logic [NUMPOPT-1:0]         vld,
   output logic [NUMPOPT*BITQUEU-1:0] idx,
   output logic [NUMPOPT*NUMQUEU-1:0] gnt
);
   always_comb begin
      logic [NUMQUEU-1:0] rem;
      logic [BITQUEU-1:0] qi;
      logic               found;
      rem   = elig;
      qi    = '0;
      found = 1'b0;
      vld   = '0;
      idx   = '0;
      gnt   = '0;
      // each port takes the first still-unclaimed queue in rotated order
      for (int i = 0; i < NUMPOPT; i++) begin
         found = 1'b0;
         for (int k = 0; k < NUMQUEU; k++) begin
            qi = BITQUEU'((int'(ptr) + k) % NUMQUEU);
            if (!found && rem[qi]) begin
               found                       = 1'b1;
               rem[qi]                     = 1'b0;
               vld[i]                      = 1'b1;
               idx[i*BITQUEU +: BITQUEU]   = qi;
               gnt[i*NUMQUEU + int'(qi)]   = 1'b1;
            end
         end
      end
   end
endmodule
`default_nettype wire

// File: rtl/algo_mrnw_queue_sched.sv
`default_nettype none
// algo_mrnw_queue_sched: round-robin pop scheduler with occupancy tracking,
// outstanding-pop credit and pause/drain sequencing.  Rev 1.0
module algo_mrnw_queue_sched
   import algo_mrnw_queue_pkg::*;
#(
   parameter int NUMQUEU = 8,
   parameter int BITQUEU = 3,
   parameter int NUMADDR = 8192,
   parameter int BITADDR = BITADDR_DFLT,
   parameter int NUMPUPT = 6,
   parameter int NUMPOPT = 1,
   parameter int MAXOUT  = 8,
   parameter int BITOUT  = 4
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       q_ready,
   input  logic [NUMPUPT-1:0]         push,
   input  logic [NUMPUPT*BITQUEU-1:0] pu_adr,
   input  logic [NUMQUEU-1:0]         req,
   input  logic                       pause,
   output logic [NUMPOPT-1:0]         pop,
   output logic [NUMPOPT*BITQUEU-1:0] po_adr,
   input  logic [NUMPOPT-1:0]         po_vld,
   output logic                       halted,
   output logic                       occ_ovf,
   output logic                       occ_udf
);
   localparam int OCC_W = BITADDR + 1;

   state_t                     state;
   logic [OCC_W-1:0]           occ [NUMQUEU];
   logic [BITOUT-1:0]          outstanding;
   logic [BITQUEU-1:0]         rr;

   logic [NUMQUEU-1:0]         elig;
   logic [NUMPOPT-1:0]         pick_vld;
   logic [NUMPOPT*BITQUEU-1:0] pick_idx;
   logic [NUMPOPT*NUMQUEU-1:0] pick_gnt;

   logic                       grant_en;
   logic [NUMPOPT-1:0]         gnt_vld;
   logic [NUMPOPT*BITQUEU-1:0] gnt_adr;
   logic [NUMQUEU-1:0]         pop_q;
   logic [BITQUEU-1:0]         rr_nx;
   int                         n_gnt;
   logic [OCC_W-1:0]           occ_nx [NUMQUEU];
   logic [BITOUT-1:0]          out_nx;
   logic                       ovf_now;
   logic                       udf_now;

   generate
      for (genvar q = 0; q < NUMQUEU; q++) begin : g_elig
         assign elig[q] = req[q] && (occ[q] != '0);
      end
   endgenerate

   algo_mrnw_rr_pick #(
      .NUMQUEU (NUMQUEU),
      .BITQUEU (BITQUEU),
      .NUMPOPT (NUMPOPT)
   ) u_pick (
      .elig (elig),
      .ptr  (rr),
      .vld  (pick_vld),
      .idx  (pick_idx),
      .gnt  (pick_gnt)
   );

   assign grant_en = (state == ST_RUN) && !pause && q_ready;

   // picks are packed from port 0, so trimming to the credit room keeps them contiguous
   always_comb begin
      int room;
      room    = (int'(outstanding) >= MAXOUT) ? 0 : MAXOUT - int'(outstanding);
      gnt_vld = '0;
      gnt_adr = '0;
      pop_q   = '0;
      rr_nx   = rr;
      n_gnt   = 0;
      for (int i = 0; i < NUMPOPT; i++) begin
         if (grant_en && pick_vld[i] && (i < room)) begin
            gnt_vld[i]                    = 1'b1;
            gnt_adr[i*BITQUEU +: BITQUEU] = pick_idx[i*BITQUEU +: BITQUEU];
            pop_q                         = pop_q | pick_gnt[i*NUMQUEU +: NUMQUEU];
            n_gnt                         = n_gnt + 1;
            rr_nx = (int'(pick_idx[i*BITQUEU +: BITQUEU]) == NUMQUEU - 1) ? '0 :
                    BITQUEU'(pick_idx[i*BITQUEU +: BITQUEU] + 1'b1);
         end
      end
   end

   always_comb begin
      int tot;
      int tot_push;
      int cnt;
      int nv;
      int vc;
      tot      = 0;
      tot_push = 0;
      cnt      = 0;
      vc       = 0;
      for (int q = 0; q < NUMQUEU; q++) tot = tot + int'(occ[q]);
      for (int p = 0; p < NUMPUPT; p++) tot_push = tot_push + int'(push[p]);
      ovf_now = (tot + tot_push) > NUMADDR;
      for (int q = 0; q < NUMQUEU; q++) begin
         cnt = 0;
         for (int p = 0; p < NUMPUPT; p++) begin
            if (push[p] && (pu_adr[p*BITQUEU +: BITQUEU] == BITQUEU'(q))) cnt = cnt + 1;
         end
         nv = int'(occ[q]) + cnt - int'(pop_q[q]);
         if (nv > NUMADDR) nv = NUMADDR;
         occ_nx[q] = OCC_W'(nv);
      end
      for (int i = 0; i < NUMPOPT; i++) vc = vc + int'(po_vld[i]);
      // returns beyond what is outstanding are unmatched; count clamps at zero
      udf_now = vc > int'(outstanding);
      nv      = int'(outstanding) + n_gnt - (udf_now ? int'(outstanding) : vc);
      out_nx  = BITOUT'(nv);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int q = 0; q < NUMQUEU; q++) occ[q] <= '0;
         outstanding <= '0;
         rr          <= '0;
         pop         <= '0;
         po_adr      <= '0;
         occ_ovf     <= 1'b0;
         occ_udf     <= 1'b0;
      end else begin
         for (int q = 0; q < NUMQUEU; q++) occ[q] <= occ_nx[q];
         outstanding <= out_nx;
         rr          <= rr_nx;
         pop         <= gnt_vld;
         po_adr      <= gnt_adr;
         if (ovf_now) occ_ovf <= 1'b1;
         if (udf_now) occ_udf <= 1'b1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state  <= ST_INIT;
         halted <= 1'b0;
      end else if (!q_ready) begin
         state  <= ST_INIT;
         halted <= 1'b0;
      end else begin
         case (state)
            ST_INIT:  state <= ST_RUN;
            ST_RUN:   if (pause) state <= ST_DRAIN;
            ST_DRAIN: if (outstanding == '0) begin
               state  <= ST_HALT;
               halted <= 1'b1;
            end
            ST_HALT:  if (!pause) begin
               state  <= ST_RUN;
               halted <= 1'b0;
            end
            default:  state <= ST_INIT;
         endcase
      end
   end
endmodule
`default_nettype wire

// File: tb/tb_algo_mrnw_queue_sched.sv
`default_nettype none
// tb_algo_mrnw_queue_sched: directed checks on a default instance and a MAXOUT=2 instance.
// Rev 1.0
module tb_algo_mrnw_queue_sched;
   import algo_mrnw_queue_pkg::*;

   localparam int NQ  = 8;
   localparam int BQ  = 3;
   localparam int NPU = 6;
   localparam int NPO = 1;

   logic              clk = 1'b0;
   logic              rst;
   logic              q_ready;
   logic              pause;
   logic [NPU-1:0]    push;
   logic [NPU*BQ-1:0] pu_adr;
   logic [NQ-1:0]     req;
   logic [NPO-1:0]    pop, pop2, po_vld, po_vld2;
   logic [NPO*BQ-1:0] po_adr, po_adr2;
   logic              halted, halted2, occ_ovf, ovf2, occ_udf, udf2;

   int n_chk  = 0;
   int n_pass = 0;

   always #5 clk = ~clk;

   algo_mrnw_queue_sched dut (
      .clk (clk), .rst (rst), .q_ready (q_ready), .push (push), .pu_adr (pu_adr),
      .req (req), .pause (pause), .pop (pop), .po_adr (po_adr), .po_vld (po_vld),
      .halted (halted), .occ_ovf (occ_ovf), .occ_udf (occ_udf)
   );

   algo_mrnw_queue_sched #(.MAXOUT (2)) dut2 (
      .clk (clk), .rst (rst), .q_ready (q_ready), .push (push), .pu_adr (pu_adr),
      .req (req), .pause (pause), .pop (pop2), .po_adr (po_adr2), .po_vld (po_vld2),
      .halted (halted2), .occ_ovf (ovf2), .occ_udf (udf2)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b0; q_ready = 1'b0; pause = 1'b0; push = '0; pu_adr = '0;
      req = '0; po_vld = '0; po_vld2 = '0;
      tick(2);
      rst = 1'b1; q_ready = 1'b1;
   endtask

   task automatic push_to(input int np, input int q);
      push = '0; pu_adr = '0;
      for (int p = 0; p < np; p++) begin
         push[p] = 1'b1;
         pu_adr[p*BQ +: BQ] = BQ'(q);
      end
   endtask

   initial begin
      rst = 1'b0; q_ready = 1'b0; pause = 1'b0; push = '0; pu_adr = '0;
      req = '0; po_vld = '0; po_vld2 = '0;
      #1;
      check("rst_pop",    32'(pop), 0);
      check("rst_po_adr", 32'(po_adr), 0);
      check("rst_halted", 32'(halted), 0);
      check("rst_ovf",    32'(occ_ovf), 0);
      check("rst_udf",    32'(occ_udf), 0);
      check("rst_dut2",   32'({pop2, po_adr2, halted2, ovf2, udf2}), 0);
      check("rst_state",  32'(dut.state), 32'(ST_INIT));

      // two pushes to queue 3 -> exactly two pops, first two cycles after the push
      do_reset();
      tick(1);
      push_to(2, 3); req = 8'h08;
      tick(1);
      push_to(0, 0);
      check("t1_no_pop_t1", 32'(pop), 0);
      tick(1);
      check("t1_pop1",      32'(pop), 1);
      check("t1_adr1",      32'(po_adr), 3);
      tick(1);
      check("t1_pop2",      32'(pop), 1);
      check("t1_adr2",      32'(po_adr), 3);
      check("t1_occ3",      32'(dut.occ[3]), 0);
      tick(1);
      check("t1_no_third",  32'(pop), 0);
      check("t1_outst",     32'(dut.outstanding), 2);

      // rr lands on 6 after a grant to queue 5, then order 7, 0, 5
      do_reset();
      tick(1);
      push_to(1, 5); req = 8'hFF;
      tick(1);
      push_to(0, 0);
      tick(1);
      check("t2_seed_adr", 32'(po_adr), 5);
      push = 6'b000111; pu_adr = '0;
      pu_adr[2:0] = 3'd0; pu_adr[5:3] = 3'd5; pu_adr[8:6] = 3'd7;
      tick(1);
      push_to(0, 0);
      check("t2_gap",  32'(pop), 0);
      tick(1);
      check("t2_pop_a", 32'({pop, po_adr}), 32'({1'b1, 3'd7}));
      tick(1);
      check("t2_pop_b", 32'({pop, po_adr}), 32'({1'b1, 3'd0}));
      tick(1);
      check("t2_pop_c", 32'({pop, po_adr}), 32'({1'b1, 3'd5}));
      tick(1);
      check("t2_done", 32'(pop), 0);

      // MAXOUT=2 instance: two pops, stall, one more after a single return
      do_reset();
      tick(1);
      push_to(5, 1); req = 8'h02;
      tick(1);
      push_to(0, 0);
      tick(1);
      check("t3_pop1",   32'(pop2), 1);
      tick(1);
      check("t3_pop2",   32'(pop2), 1);
      tick(1);
      check("t3_stall1", 32'(pop2), 0);
      tick(1);
      check("t3_stall2", 32'(pop2), 0);
      check("t3_occ1",   32'(dut2.occ[1]), 3);
      po_vld2 = 1'b1;
      tick(1);
      po_vld2 = 1'b0;
      check("t3_stall3", 32'(pop2), 0);
      tick(1);
      check("t3_pop3",   32'({pop2, po_adr2}), 32'({1'b1, 3'd1}));
      tick(1);
      check("t3_stall4", 32'(pop2), 0);

      // pause with three pops outstanding, drain, halt, resume
      do_reset();
      tick(1);
      push_to(4, 2); req = 8'h04;
      tick(1);
      push_to(0, 0);
      tick(3);
      pause = 1'b1;
      check("t4_pop_pre",  32'(pop), 1);
      check("t4_outst3",   32'(dut.outstanding), 3);
      tick(1);
      check("t4_pop_stop", 32'(pop), 0);
      check("t4_drain",    32'(dut.state), 32'(ST_DRAIN));
      check("t4_halt_lo1", 32'(halted), 0);
      po_vld = 1'b1;
      tick(2);
      check("t4_halt_lo2", 32'(halted), 0);
      tick(1);
      po_vld = 1'b0;
      check("t4_outst0",   32'(dut.outstanding), 0);
      check("t4_halt_lo3", 32'(halted), 0);
      tick(1);
      check("t4_halted",   32'(halted), 1);
      pause = 1'b0;
      tick(1);
      check("t4_unhalt",   32'(halted), 0);
      check("t4_no_pop",   32'(pop), 0);
      tick(1);
      check("t4_resume",   32'({pop, po_adr}), 32'({1'b1, 3'd2}));

      // fill to NUMADDR exactly, then one more push; unmatched return
      do_reset();
      push_to(6, 0);
      tick(1365);
      push_to(2, 0);
      tick(1);
      push_to(0, 0);
      check("t5_full_noovf", 32'(occ_ovf), 0);
      check("t5_full_occ",   32'(dut.occ[0]), 8192);
      push_to(1, 0);
      tick(1);
      push_to(0, 0);
      check("t5_ovf",        32'(occ_ovf), 1);
      check("t5_sat",        32'(dut.occ[0]), 8192);
      tick(3);
      check("t5_ovf_sticky", 32'(occ_ovf), 1);
      check("t5_no_udf",     32'(occ_udf), 0);
      po_vld = 1'b1;
      tick(1);
      po_vld = 1'b0;
      check("t5_udf",        32'(occ_udf), 1);
      check("t5_outst_hold", 32'(dut.outstanding), 0);

      // asynchronous reset in the middle of a drain
      do_reset();
      tick(1);
      push_to(2, 4); req = 8'h10; po_vld = 1'b1;
      tick(1);
      push_to(0, 0); po_vld = 1'b0;
      check("t6_udf_pre", 32'(occ_udf), 1);
      tick(2);
      pause = 1'b1;
      tick(1);
      check("t6_drain",   32'(dut.state), 32'(ST_DRAIN));
      check("t6_outst2",  32'(dut.outstanding), 2);
      #2;
      rst = 1'b0;
      #1;
      check("t6_async_out", 32'({pop, po_adr, halted, occ_ovf, occ_udf}), 0);
      check("t6_async_st",  32'(dut.state), 32'(ST_INIT));
      check("t6_async_cnt", 32'(dut.outstanding), 0);
      @(posedge clk);
      #1;
      rst = 1'b1; q_ready = 1'b0; pause = 1'b0; po_vld = 1'b1;
      tick(1);
      po_vld = 1'b0;
      check("t6_late_udf",  32'(occ_udf), 1);
      check("t6_late_cnt",  32'(dut.outstanding), 0);
      tick(2);
      check("t6_qr_low",    32'(pop), 0);
      q_ready = 1'b1;
      tick(3);
      check("t6_no_push",   32'(pop), 0);
      push_to(1, 4);
      tick(1);
      push_to(0, 0);
      check("t6_wait",      32'(pop), 0);
      tick(1);
      check("t6_new_pop",   32'({pop, po_adr}), 32'({1'b1, 3'd4}));

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule
`default_nettype wire
